// File: rtl/adc_stream_ctrl_if.sv
// FT245R receive-side and stream-writer handshake shared by the pins, the writer and the
// command sequencer; the sequencer uses the slave modport.
interface adc_stream_ctrl_if;
    logic       usb_rxf_;
    logic [7:0] usb_din;
    logic       usb_rd_;
    logic       stream_req;
    logic       stream_gnt;

    // master: FT245R pins plus the stream writer; slave: sequencer/arbiter
    modport master (
        output usb_rxf_,
        output usb_din,
        output stream_req,
        input  usb_rd_,
        input  stream_gnt
    );

    modport slave (
        input  usb_rxf_,
        input  usb_din,
        input  stream_req,
        output usb_rd_,
        output stream_gnt
    );
endinterface

// File: rtl/adc_stream_ctrl.sv
// CS5361 command sequencer and FT245R half-duplex bus arbiter.
// Optional ADC_OVFL_LATCH_EN adds the adc_ovfl_ input and a sticky overflow flag on status[6].
module adc_stream_ctrl #(
    parameter int unsigned RST_CYCLES    = 1024,
    parameter int unsigned SETTLE_CYCLES = 4096,
    parameter int unsigned RD_PULSE      = 3
) (
    input  logic              clk,
    input  logic              rst_,
    adc_stream_ctrl_if.slave  bus,
`ifdef ADC_OVFL_LATCH_EN
    input  logic              adc_ovfl_,
`endif
    output logic              adc_reset_,
    output logic [5:0]        adc_cfg,
    output logic              stream_en,
    output logic              cmd_err,
    output logic [7:0]        status
);

    localparam int unsigned CntMax = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax) + 1;

    localparam logic [1:0] OpNop    = 2'b00;
    localparam logic [1:0] OpSetCfg = 2'b01;
    localparam logic [1:0] OpStart  = 2'b10;
    localparam logic [1:0] OpStop   = 2'b11;

    // Codes chosen so every transition touching GRANT or RD_LOW flips one bit, keeping the
    // decoded strobes glitch-free.
    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StGrant     = 3'd1,
        StRdLow     = 3'd2,
        StRdRec     = 3'd3,
        StDecode    = 3'd4,
        StAdcRst    = 3'd5,
        StAdcSettle = 3'd6
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      cmd_byte_q, cmd_byte_d;
    logic [5:0]      adc_cfg_q, adc_cfg_d;
    logic            adc_reset_q, adc_reset_d;
    logic            stream_en_q, stream_en_d;
    logic            cmd_err_q, cmd_err_d;
    logic            ovfl_clr;
    logic            ovfl;
    logic            busy;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q       <= '0;
            cmd_byte_q  <= '0;
            adc_cfg_q   <= '0;
            adc_reset_q <= 1'b0;
            stream_en_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cmd_byte_q  <= cmd_byte_d;
            adc_cfg_q   <= adc_cfg_d;
            adc_reset_q <= adc_reset_d;
            stream_en_q <= stream_en_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != '0) ? cnt_q - CntW'(1) : cnt_q;
        cmd_byte_d  = cmd_byte_q;
        adc_cfg_d   = adc_cfg_q;
        adc_reset_d = adc_reset_q;
        stream_en_d = stream_en_q;
        cmd_err_d   = cmd_err_q;
        ovfl_clr    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Command reads win over the writer so a STOP is never starved.
                if (!bus.usb_rxf_) begin
                    state_d = StRdLow;
                    cnt_d   = CntW'(RD_PULSE - 1);
                end else if (bus.stream_req) begin
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (!bus.stream_req) begin
                    state_d = StIdle;
                end
            end
            StRdLow: begin
                if (cnt_q == '0) begin
                    cmd_byte_d = bus.usb_din;
                    state_d    = StRdRec;
                    cnt_d      = CntW'(1);
                end
            end
            StRdRec: begin
                if (cnt_q == '0) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StIdle;
                unique case (cmd_byte_q[7:6])
                    OpNop: begin
                        cmd_err_d = 1'b0;
                    end
                    OpSetCfg: begin
                        if (stream_en_q) begin
                            cmd_err_d = 1'b1;
                        end else begin
                            adc_cfg_d = cmd_byte_q[5:0];
                        end
                    end
                    OpStart: begin
                        ovfl_clr = 1'b1;
                        if (!stream_en_q) begin
                            adc_reset_d = 1'b0;
                            state_d     = StAdcRst;
                            cnt_d       = CntW'(RST_CYCLES - 1);
                        end
                    end
                    OpStop: begin
                        ovfl_clr    = 1'b1;
                        stream_en_d = 1'b0;
                    end
                endcase
            end
            StAdcRst: begin
                if (cnt_q == '0) begin
                    adc_reset_d = 1'b1;
                    state_d     = StAdcSettle;
                    cnt_d       = CntW'(SETTLE_CYCLES - 1);
                end
            end
            StAdcSettle: begin
                if (cnt_q == '0) begin
                    stream_en_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef ADC_OVFL_LATCH_EN
    logic [1:0] ovfl_sync_q;
    logic       ovfl_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ovfl_sync_q <= 2'b11;
            ovfl_q      <= 1'b0;
        end else begin
            ovfl_sync_q <= {ovfl_sync_q[0], adc_ovfl_};
            if (ovfl_clr) begin
                ovfl_q <= 1'b0;
            end else if (!ovfl_sync_q[1] && stream_en_q) begin
                ovfl_q <= 1'b1;
            end
        end
    end

    assign ovfl = ovfl_q;
`else
    logic unused_ovfl_clr;
    assign unused_ovfl_clr = ovfl_clr;
    assign ovfl            = 1'b0;
`endif

    always_comb begin
        bus.usb_rd_    = (state_q != StRdLow);
        bus.stream_gnt = (state_q == StGrant);
        busy           = (state_q == StAdcRst) || (state_q == StAdcSettle);
        adc_reset_     = adc_reset_q;
        adc_cfg        = adc_cfg_q;
        stream_en      = stream_en_q;
        cmd_err        = cmd_err_q;
        status         = {stream_en_q, ovfl, cmd_err_q, busy, 1'b0, state_q};
    end

endmodule

// File: tb/tb_adc_stream_ctrl.sv
// Scoreboard bench for adc_stream_ctrl: command/writer stimulus pushes expectations into
// per-event queues, an independent monitor pops them as the DUT shows each event.
module tb_adc_stream_ctrl;

    localparam int RstCycles    = 1024;
    localparam int SettleCycles = 4096;
    localparam int RdPulse      = 3;
    localparam int Timeout      = 12000;

    typedef struct packed {
        logic [5:0] cfg;
        logic       err;
        logic       en;
        logic       arst;
        logic       ovfl;
        logic [3:0] nxt;
    } cmd_exp_t;

    logic       clk = 1'b0;
    logic       rst_;
    logic       adc_reset_;
    logic [5:0] adc_cfg;
    logic       stream_en;
    logic       cmd_err;
    logic [7:0] status;
`ifdef ADC_OVFL_LATCH_EN
    logic       adc_ovfl_;
`endif

    adc_stream_ctrl_if bus();

    adc_stream_ctrl dut (
        .clk        (clk),
        .rst_       (rst_),
        .bus        (bus),
`ifdef ADC_OVFL_LATCH_EN
        .adc_ovfl_  (adc_ovfl_),
`endif
        .adc_reset_ (adc_reset_),
        .adc_cfg    (adc_cfg),
        .stream_en  (stream_en),
        .cmd_err    (cmd_err),
        .status     (status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model of the host-visible command effects.
    logic [5:0] m_cfg  = '0;
    logic       m_err  = 1'b0;
    logic       m_en   = 1'b0;
    logic       m_arst = 1'b0;
    logic       m_ovfl = 1'b0;

    cmd_exp_t cmd_q[$];
    int       rd_q[$];
    int       rst_q[$];
    int       en_q[$];
    bit       gnt_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_usb_rd"},     32'(bus.usb_rd_),    1);
        check({tag, "_stream_gnt"}, 32'(bus.stream_gnt), 0);
        check({tag, "_adc_reset"},  32'(adc_reset_),     0);
        check({tag, "_adc_cfg"},    32'(adc_cfg),        0);
        check({tag, "_stream_en"},  32'(stream_en),      0);
        check({tag, "_cmd_err"},    32'(cmd_err),        0);
        check({tag, "_status"},     32'(status),         0);
    endtask

    task automatic issue_cmd(input logic [7:0] b);
        cmd_exp_t e;
        logic     launch;
        launch = 1'b0;
        case (b[7:6])
            2'b00: m_err = 1'b0;
            2'b01: begin
                if (m_en) m_err = 1'b1;
                else      m_cfg = b[5:0];
            end
            2'b10: begin
                m_ovfl = 1'b0;
                launch = !m_en;
            end
            default: begin
                m_ovfl = 1'b0;
                m_en   = 1'b0;
            end
        endcase
        e.cfg  = m_cfg;
        e.err  = m_err;
        e.en   = m_en;
        e.arst = launch ? 1'b0 : m_arst;
        e.ovfl = m_ovfl;
        e.nxt  = launch ? 4'd5 : 4'd0;
        cmd_q.push_back(e);
        rd_q.push_back(RdPulse);
        if (launch) begin
            rst_q.push_back(RstCycles);
            en_q.push_back(SettleCycles);
            m_en   = 1'b1;
            m_arst = 1'b1;
        end
        bus.usb_din  = b;
        bus.usb_rxf_ = 1'b0;
    endtask

    task automatic finish_read();
        int n;
        n = 0;
        while (bus.usb_rd_ !== 1'b0 && n < Timeout) begin
            step();
            n++;
        end
        if (n >= Timeout) fail("rd_start", "got no usb_rd_ strobe, required one within timeout");
        n = 0;
        while (bus.usb_rd_ !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        if (n >= 16) fail("rd_end", "got usb_rd_ stuck low, required release");
        bus.usb_rxf_ = 1'b1;
        bus.usb_din  = 8'($urandom);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        issue_cmd(b);
        finish_read();
    endtask

    task automatic wait_gnt();
        int n;
        n = 0;
        while (bus.stream_gnt !== 1'b1 && n < Timeout) begin
            step();
            n++;
        end
        if (n >= Timeout) fail("gnt_wait", "got no stream_gnt, required one within timeout");
    endtask

    task automatic writer_burst(input int unsigned hold);
        bus.stream_req = 1'b1;
        gnt_q.push_back(1'b1);
        wait_gnt();
        repeat (hold) step();
        bus.stream_req = 1'b0;
        step();
        check("gnt_release", 32'(bus.stream_gnt), 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rd_q.size() + cmd_q.size() + rst_q.size() + en_q.size() + gnt_q.size()) != 0
               && n < Timeout) begin
            step();
            n++;
        end
        if (n >= Timeout) fail("drain", "got pending expected events, required all observed");
    endtask

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    logic [3:0] prev_state;
    logic [3:0] cur_state;
    logic       prev_rd, prev_arst, prev_en, prev_gnt, settling;
    int         rd_cnt, rst_cnt, settle_cnt;
    cmd_exp_t   mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_) begin
                prev_state = 4'd0;
                prev_rd    = 1'b1;
                prev_arst  = 1'b0;
                prev_en    = 1'b0;
                prev_gnt   = 1'b0;
                settling   = 1'b0;
                rd_cnt     = 0;
                rst_cnt    = 0;
                settle_cnt = 0;
            end else begin
                cur_state = status[3:0];
                if (!bus.usb_rd_) begin
                    rd_cnt++;
                end else if (!prev_rd) begin
                    if (rd_q.size() == 0) fail("unexpected_read", "got a read strobe, required none");
                    else check("rd_pulse_len", rd_cnt, rd_q.pop_front());
                    rd_cnt = 0;
                end
                if (prev_state == 4'd4 && cur_state != 4'd4) begin
                    if (cmd_q.size() == 0) begin
                        fail("unexpected_decode", "got a decode, required none");
                    end else begin
                        mon_e = cmd_q.pop_front();
                        check("cmd_adc_cfg",   32'(adc_cfg),    32'(mon_e.cfg));
                        check("cmd_err",       32'(cmd_err),    32'(mon_e.err));
                        check("cmd_stream_en", 32'(stream_en),  32'(mon_e.en));
                        check("cmd_adc_reset", 32'(adc_reset_), 32'(mon_e.arst));
                        check("cmd_next_st",   32'(cur_state),  32'(mon_e.nxt));
                        check("cmd_ovfl",      32'(status[6]),  32'(mon_e.ovfl));
                    end
                end
                if (cur_state == 4'd5 && prev_state != 4'd5) rst_cnt = 1;
                else if (!adc_reset_) rst_cnt++;
                if (adc_reset_ && !prev_arst) begin
                    if (rst_q.size() == 0) fail("unexpected_arst", "got adc_reset_ rise, required none");
                    else check("adc_reset_low_len", rst_cnt, rst_q.pop_front());
                    settle_cnt = 0;
                    settling   = 1'b1;
                end else if (settling) begin
                    settle_cnt++;
                end
                if (stream_en && !prev_en) begin
                    if (en_q.size() == 0) fail("unexpected_en", "got stream_en rise, required none");
                    else check("settle_len", settle_cnt, en_q.pop_front());
                    settling = 1'b0;
                end
                if (bus.stream_gnt) begin
                    check("gnt_exclusive", {30'd0, bus.usb_rd_, status[4]}, 32'b10);
                    if (!prev_gnt) begin
                        if (gnt_q.size() == 0) begin
                            fail("unexpected_gnt", "got stream_gnt, required none");
                        end else begin
                            check("gnt_req", 32'(bus.stream_req), 32'(gnt_q.pop_front()));
                        end
                    end
                end
                prev_state = cur_state;
                prev_rd    = bus.usb_rd_;
                prev_arst  = adc_reset_;
                prev_en    = stream_en;
                prev_gnt   = bus.stream_gnt;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_           = 1'b1;
        bus.usb_rxf_   = 1'b1;
        bus.usb_din    = 8'h00;
        bus.stream_req = 1'b0;
`ifdef ADC_OVFL_LATCH_EN
        adc_ovfl_      = 1'b1;
`endif
        #3 rst_ = 1'b0;
        #1 check_reset_vals("reset");
        repeat (3) step();
        rst_ = 1'b1;
        repeat (2) step();

        // Reset asserted in the middle of a read strobe aborts it immediately.
        bus.usb_din  = 8'h55;
        bus.usb_rxf_ = 1'b0;
        n = 0;
        while (bus.usb_rd_ !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) fail("abort_rd_start", "got no usb_rd_ strobe, required one");
        step();
        #2 rst_ = 1'b0;
        #1 check_reset_vals("abort");
        bus.usb_rxf_ = 1'b1;
        repeat (2) step();
        rst_ = 1'b1;
        repeat (2) step();

        send_cmd(8'h55);
        drain();
        send_cmd(8'h80);
        drain();
        check("streaming_after_start", 32'(stream_en), 1);
        send_cmd(8'h7F);
        send_cmd(8'h00);
        drain();

        // Read and grant requested together: the read goes first.
        bus.stream_req = 1'b1;
        gnt_q.push_back(1'b1);
        issue_cmd(8'h01);
        n = 0;
        while (bus.usb_rd_ !== 1'b0 && bus.stream_gnt !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("prio_read_first", 32'(bus.stream_gnt), 0);
        finish_read();
        wait_gnt();
        issue_cmd(8'h00);
        for (int i = 0; i < 8; i++) begin
            step();
            check("gnt_blocks_rd", 32'(bus.usb_rd_), 1);
        end
        bus.stream_req = 1'b0;
        step();
        check("gnt_drop", 32'(bus.stream_gnt), 0);
        finish_read();
        drain();

`ifdef ADC_OVFL_LATCH_EN
        adc_ovfl_ = 1'b0;
        repeat (2) step();
        adc_ovfl_ = 1'b1;
        repeat (4) step();
        check("ovfl_latch", 32'(status[6]), 1);
        m_ovfl = 1'b1;
`endif
        send_cmd(8'hC0);
        drain();

        fork
            begin : cmd_thread
                int starts;
                logic [7:0] b;
                starts = 0;
                for (int i = 0; i < 24; i++) begin
                    b = 8'($urandom);
                    if (b[7:6] == 2'b10) begin
                        if (starts >= 2) b[7:6] = 2'b11;
                        else starts++;
                    end
                    send_cmd(b);
                    repeat ($urandom_range(0, 3)) step();
                end
            end
            begin : writer_thread
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(1, 40)) step();
                    writer_burst($urandom_range(1, 4));
                end
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
